// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, line levels and DATA_BITS limits for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP = 1'b1;
  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 9;
  localparam int UART_BIT_CNT_W = $clog2(UART_DATA_BITS_MAX + 1);
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; tick marks the last clock of a bit, pre_tick says the next clock is a tick
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             pre_tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;
  assign tick = cnt >= last;
  assign pre_tick = last == '0 || cnt == last - 1'b1;
  // latch the terminal count on load (divisor 0 acts as 1) and restart the count on every bit boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      last <= '0;
    end else begin
      cnt <= load || tick ? '0 : cnt + 1'b1;
      if (load) last <= div == '0 ? '0 : div - 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter; define UART_TX_PARITY_EN to build the parity bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 stop2,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int BC_W = UART_BIT_CNT_W;
  uart_tx_state_t state, st_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BC_W-1:0] bit_cnt, bit_cnt_n;
  logic stop_idx, stop_idx_n, stop2_q;
  logic xfer, tick, pre_tick, last_n, tx_n, par_go, par_lvl;
  assign xfer = s_valid & s_ready;
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk(clk),
    .reset(reset),
    .load(xfer),
    .div(baud_div),
    .tick(tick),
    .pre_tick(pre_tick)
  );
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_q;
  assign par_go = par_en_q;
  assign par_lvl = par_q;
  // capture parity mode and the parity of the word at transfer time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_en_q <= 1'b0;
      par_q <= 1'b0;
    end else if (xfer) begin
      par_en_q <= parity_en;
      par_q <= ^s_data ^ parity_odd;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
  assign par_go = 1'b0;
  assign par_lvl = UART_STOP;
`endif
  // next state plus the values the registered outputs take in the next clock
  always_comb begin
    st_n = state;
    case (state)
      IDLE: st_n = xfer ? START : IDLE;
      START: st_n = tick ? DATA : START;
      DATA: if (tick && bit_cnt == BC_W'(DATA_BITS - 1)) st_n = par_go ? PARITY : STOP;
`ifdef UART_TX_PARITY_EN
      PARITY: st_n = tick ? STOP : PARITY;
`endif
      STOP: if (tick && stop_idx == stop2_q) st_n = xfer ? START : IDLE;
      default: st_n = IDLE;
    endcase
    shreg_n = xfer ? s_data : state == DATA && tick ? shreg >> 1 : shreg;
    bit_cnt_n = state != DATA ? '0 : tick ? bit_cnt + 1'b1 : bit_cnt;
    stop_idx_n = st_n != STOP ? 1'b0 : state == STOP && tick ? 1'b1 : stop_idx;
    last_n = st_n == STOP && stop_idx_n == stop2_q && pre_tick;
    tx_n = st_n == START ? UART_START : st_n == DATA ? shreg_n[0] : st_n == PARITY ? par_lvl : UART_STOP;
  end
  // frame sequencer with registered pad and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      stop_idx <= 1'b0;
      stop2_q <= 1'b0;
      tx <= UART_STOP;
      busy <= 1'b0;
      s_ready <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= st_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      stop_idx <= stop_idx_n;
      if (xfer) stop2_q <= stop2;
      tx <= tx_n;
      busy <= st_n != IDLE;
      s_ready <= st_n == IDLE || last_n;
      frame_done <= last_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of frame shape, handshake, divisor latching and reset for uart_tx_frame
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] baud_div = 16'd1;
  logic stop2 = 1'b0;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic tx, busy, frame_done;
  int checks = 0;
  int failures = 0;

  uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .baud_div(baud_div),
    .stop2(stop2),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] dv, input logic s2, input logic pe, input logic po);
    s_data = d;
    baud_div = dv;
    stop2 = s2;
    parity_en = pe;
    parity_odd = po;
    s_valid = 1'b1;
    step;
    s_valid = 1'b0;
  endtask

  task automatic watch(input string tag, input logic [11:0] fr, input int nb, input int dv);
    string t;
    for (int i = 0; i < nb * dv; i++) begin
      t = $sformatf("%s[%0d]", tag, i);
      chk({t, ".tx"}, tx, fr[i / dv]);
      chk({t, ".busy"}, busy, 1'b1);
      chk({t, ".s_ready"}, s_ready, i == nb * dv - 1);
      chk({t, ".frame_done"}, frame_done, i == nb * dv - 1);
      step;
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".tx"}, tx, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".s_ready"}, s_ready, 1'b1);
    chk({tag, ".frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    step;
    idle_chk("reset");
    reset = 1'b0;
    step;
    idle_chk("post_reset");

    send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0);
    watch("8n1_a5", {1'b1, 8'hA5, 1'b0}, 10, 4);
    idle_chk("8n1_end");

`ifdef UART_TX_PARITY_EN
    send(8'h07, 16'd2, 1'b0, 1'b1, 1'b0);
    watch("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 2);
    send(8'h07, 16'd2, 1'b0, 1'b1, 1'b1);
    watch("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 2);
`else
    send(8'h07, 16'd2, 1'b0, 1'b1, 1'b0);
    watch("par_off", {1'b1, 8'h07, 1'b0}, 10, 2);
`endif
    idle_chk("par_end");

    s_data = 8'h55;
    baud_div = 16'd4;
    stop2 = 1'b0;
    parity_en = 1'b0;
    s_valid = 1'b1;
    step;
    s_data = 8'hAA;
    watch("b2b_55", {1'b1, 8'h55, 1'b0}, 10, 4);
    s_valid = 1'b0;
    watch("b2b_aa", {1'b1, 8'hAA, 1'b0}, 10, 4);
    idle_chk("b2b_end");

    send(8'h3C, 16'd3, 1'b1, 1'b0, 1'b0);
    watch("stop2", {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 3);
    idle_chk("stop2_end");

    send(8'h81, 16'd0, 1'b0, 1'b0, 1'b0);
    baud_div = 16'd8;
    s_data = 8'h00;
    stop2 = 1'b1;
    watch("div0", {1'b1, 8'h81, 1'b0}, 10, 1);
    idle_chk("div0_end");
    s_data = 8'h81;
    stop2 = 1'b0;
    s_valid = 1'b1;
    step;
    s_valid = 1'b0;
    watch("div8", {1'b1, 8'h81, 1'b0}, 10, 8);
    idle_chk("div8_end");

    send(8'h00, 16'd4, 1'b0, 1'b0, 1'b0);
    repeat (10) step;
    chk("pre_reset.tx", tx, 1'b0);
    chk("pre_reset.busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    idle_chk("mid_reset");
    step;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("after_reset[%0d].frame_done", i), frame_done, 1'b0);
      chk($sformatf("after_reset[%0d].tx", i), tx, 1'b1);
      step;
    end
    send(8'h5A, 16'd2, 1'b0, 1'b0, 1'b0);
    watch("clean", {1'b1, 8'h5A, 1'b0}, 10, 2);
    idle_chk("clean_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Data width is set at build time. Baud divisor, stop-bit count and parity mode are run-time inputs, latched once per frame. Input uses a level valid/ready handshake, and back-to-back frames go out with no idle gap. The block sits between a byte/word source (CPU register bank or FIFO) and the `tx` pad.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `DIV_W`, default 16: width of the run-time baud divisor.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `s_data` in `DATA_BITS`: word to send, LSB first.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: block accepts a word this cycle. Transfer happens when `s_valid & s_ready`.
- `baud_div` in `DIV_W`: clocks per bit. 0 is treated as 1.
- `stop2` in 1: 1 = two stop bits, 0 = one stop bit.
- `parity_en` in 1: append a parity bit.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `tx` out 1: serial line; idles high.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse in the last cycle of the last stop bit.

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- On transfer, the block latches `s_data`, `baud_div`, `stop2`, `parity_en` and `parity_odd`. Changes to these inputs mid-frame have no effect on the current frame.
- Parity bit = XOR of the latched data bits, inverted when odd parity is selected.
- Transitions, each after one bit period:
  - `IDLE` → `START` on transfer.
  - `START` → `DATA`.
  - `DATA` → `PARITY` after `DATA_BITS` bits, if parity is enabled; otherwise → `STOP`.
  - `PARITY` → `STOP`.
  - `STOP` → `IDLE` after 1 or 2 stop bits, or → `START` if a transfer happens in the final stop cycle.
- Bit period = `max(baud_div,1)` clocks, counted by a `DIV_W`-bit counter that restarts on each bit boundary. The counter never wraps past the latched divisor.
- `tx` levels: `START` = 0, `DATA` = shift-register LSB, `PARITY` = parity bit, `STOP` = 1, `IDLE` = 1.
- `s_ready` is high in `IDLE`, and in the final clock of the final stop bit. It is low at all other times.
- Frame length in clocks = `div × (1 + DATA_BITS + P + S)`, where P = parity enabled (0 or 1) and S = stop-bit count (1 or 2).

## Timing
- Reset values: `tx`=1, `s_ready`=1 (state `IDLE`), `busy`=0, `frame_done`=0. All counters are 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and the frame is discarded. No `frame_done` is produced.
- Latency: `tx` falls in the clock after the transfer cycle. `busy` rises in the same clock.
- `tx` and `busy` are registered outputs, so there are no glitches on the pad.
- Back-to-back: with `s_valid` held high, the next start bit directly follows the last stop clock, with zero idle clocks.
- `frame_done` and the next transfer may occur in the same cycle. If there is no new transfer, `busy` falls in the next clock.
- `s_valid` high while `s_ready` is low: the word is held by the source, not dropped. The block never samples `s_data` outside a transfer.

## Configuration
- `UART_TX_PARITY_EN` defined: the parity state and parity logic are built, and `parity_en`/`parity_odd` behave as described above.
- `UART_TX_PARITY_EN` not defined: the `PARITY` state and parity XOR are removed, and `parity_en`/`parity_odd` are ignored. The ports stay present so the interface does not change. Frames are always `1 + DATA_BITS + S` bits.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_t` enum covering the five states.
  - Localparams `UART_START` = 0 and `UART_STOP` = 1.
  - Legal-range constants for `DATA_BITS`.
- Sub-module `uart_baud_gen`: bit-period counter. Inputs are `clk`, `reset`, `load`, `div[DIV_W-1:0]`. Outputs are `tick` (last clock of the bit) and `pre_tick`. The transmitter FSM, shift register and parity logic stay in `uart_tx_frame`.

## Test plan
- 8N1, `baud_div`=4, `s_data`=0xA5 → `tx` = 0, 1,0,1,0,0,1,0,1, 1, each level for exactly 4 clocks. `frame_done` pulses at clock 40 after the transfer.
- `parity_en`=1, `s_data`=0x07 → parity bit 1 with even parity (`parity_odd`=0), 0 with odd parity (`parity_odd`=1). Frame is 11 bits. With the macro undefined, the frame is 10 bits and has no parity bit.
- `s_valid` held high with 0x55 then 0xAA, `baud_div`=4, 1 stop bit → the second start bit begins on the clock right after the first stop bit. Total 80 clocks, and `busy` never drops between the frames.
- `stop2`=1, `baud_div`=3 → stop level held for 6 clocks. `s_ready` is high only in the last of those 6 clocks.
- `baud_div`=0 → 1 clock per bit. Then `baud_div` changed to 8 mid-frame → the current frame keeps 1 clock per bit, and the next frame uses 8.
- `reset` pulsed during the data bits → `tx`=1 immediately, `s_ready`=1, no `frame_done`. The next transfer produces a clean full frame.
